// File: rtl/rx_ctrl.sv
// rx_ctrl: receive-side controller for the UART receiver.
//
// Generates the receiver sample clock from a programmable half-period
// divisor. Drains each completed character (i_rx_rdy/i_rx_data) with a
// one-cycle read-enable pulse. Buffers the character in a small circular
// FIFO that the host reads through a valid/ready port. A sticky overrun
// flag records any character that was dropped because the FIFO was full.
//
// Ports:
//   i_clk, i_nrst        clock; synchronous active-low reset
//   i_en                 enables the baud generator and new captures
//   i_div                half-period of o_clk_rx is i_div+1 cycles
//   o_clk_rx             sample clock to the receiver
//   i_rx_rdy, i_rx_data  receiver character-ready flag and data
//   o_rx_re              one-cycle read-enable pulse to the receiver
//   o_valid, o_data      FIFO head (valid when non-empty)
//   i_ready              host pop, taken when o_valid && i_ready
//   o_count              FIFO occupancy
//   o_overrun, i_clr_ovr sticky drop flag and its clear
module rx_ctrl #(
  parameter int WIDTH_DATA = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_en,
  input  logic [DIV_WIDTH-1:0]          i_div,
  output logic                          o_clk_rx,
  input  logic                          i_rx_rdy,
  input  logic [WIDTH_DATA-1:0]         i_rx_data,
  output logic                          o_rx_re,
  output logic                          o_valid,
  output logic [WIDTH_DATA-1:0]         o_data,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overrun,
  input  logic                          i_clr_ovr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic                  clk_rx_q;

  state_t                state;
  state_t                state_nxt;
  logic                  re_q;
  logic                  push;

  logic [WIDTH_DATA-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  ovr_q;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;

  // Baud generator. The >= compare (not ==) lets a divisor lowered below the
  // current count wrap on the next cycle instead of running to 2^DIV_WIDTH.
  always_ff @(posedge i_clk) begin
    if (!i_nrst || !i_en) begin
      baud_cnt <= '0;
      clk_rx_q <= 1'b0;
    end else if (baud_cnt >= i_div) begin
      baud_cnt <= '0;
      clk_rx_q <= ~clk_rx_q;
    end else begin
      baud_cnt <= baud_cnt + DIV_WIDTH'(1);
    end
  end

  assign o_clk_rx = clk_rx_q;

  // Drain FSM: state register. The read-enable is registered from the
  // next state so it is a clean flop output, high exactly while in ACK.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state <= S_IDLE;
      re_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      re_q  <= (state_nxt == S_ACK);
    end
  end

  // Drain FSM: next state. WAIT holds until rdy falls so a slow-falling
  // rdy never causes a second capture of the same character.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_en && i_rx_rdy) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_WAIT;
      S_WAIT:  if (!i_rx_rdy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Drain FSM: outputs. The capture happens on the IDLE->ACK edge.
  always_comb begin
    push = (state == S_IDLE) && i_en && i_rx_rdy;
  end

  assign o_rx_re = re_q;

  // A full FIFO still accepts a push when the host pops in the same cycle.
  always_comb begin
    pop     = (count != '0) && i_ready;
    push_ok = push && ((count != DEPTH_C) || pop);
    drop    = push && !push_ok;
  end

  // Storage carries no reset; stale entries are never visible because
  // o_data is gated by o_valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)           ovr_q <= 1'b1;
      else if (i_clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign o_valid   = (count != '0);
  assign o_data    = o_valid ? mem[rd_ptr] : '0;
  assign o_count   = count;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Testbench for rx_ctrl: directed scenarios plus a randomized run, checked
// against a queue-based model of the character FIFO and an arithmetic model
// of the baud divider.
module tb_rx_ctrl;

  localparam int WD    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          i_nrst, i_en, i_rx_rdy, i_ready, i_clr_ovr;
  logic [DW-1:0] i_div;
  logic [WD-1:0] i_rx_data;
  logic          o_clk_rx, o_rx_re, o_valid, o_overrun;
  logic [WD-1:0] o_data;
  logic [2:0]    o_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         m_ovr;

  always #5 clk = ~clk;

  rx_ctrl #(.WIDTH_DATA(WD), .DIV_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_nrst(i_nrst), .i_en(i_en), .i_div(i_div),
    .o_clk_rx(o_clk_rx), .i_rx_rdy(i_rx_rdy), .i_rx_data(i_rx_data),
    .o_rx_re(o_rx_re), .o_valid(o_valid), .o_data(o_data),
    .i_ready(i_ready), .o_count(o_count), .o_overrun(o_overrun),
    .i_clr_ovr(i_clr_ovr)
  );

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Acts as the receiver: presents a character, optionally with a host pop
  // and/or an overrun clear on the same edge, holds rdy for `hold` cycles
  // after the ack cycle, and counts read-enable pulses.
  task automatic send_char(input logic [7:0] d, input int hold, input bit with_pop,
                           input bit with_clr, output int pulses, output int first,
                           output logic [7:0] head_before);
    i_rx_rdy = 1'b1; i_rx_data = d; i_ready = with_pop; i_clr_ovr = with_clr;
    head_before = o_data;
    step();
    i_ready = 1'b0; i_clr_ovr = 1'b0;
    if (with_pop && q.size() != 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back(d);
    else m_ovr = 1'b1;
    if (with_clr && q.size() < DEPTH && !m_ovr) m_ovr = 1'b0;
    pulses = 0; first = -1;
    for (int c = 0; c < hold + 4; c++) begin
      if (o_rx_re === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (c == hold) i_rx_rdy = 1'b0;
      step();
    end
  endtask

  task automatic pop_one(output logic [7:0] got, output bit got_valid);
    got_valid = o_valid; got = o_data;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clr_ovr();
    i_clr_ovr = 1'b1;
    step();
    i_clr_ovr = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_clk_rx !== 1'b0) begin failures++; $display("FAIL reset_clk_rx got=%b exp=0", o_clk_rx); end
    checks++; if (o_rx_re !== 1'b0) begin failures++; $display("FAIL reset_rx_re got=%b exp=0", o_rx_re); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", o_overrun); end
    checks++; if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_data); end
  endtask

  task automatic test_divisor();
    int d; logic exp;
    for (int r = 0; r < 4; r++) begin
      d = (r == 0) ? 3 : $urandom_range(0, 5);
      i_en = 1'b0; i_div = DW'(d);
      step();
      i_en = 1'b1;
      // After k enabled edges the output has toggled floor(k/(d+1)) times.
      for (int k = 1; k <= 4 * (d + 1) + 1; k++) begin
        step();
        exp = ((k / (d + 1)) % 2) != 0;
        checks++;
        if (o_clk_rx !== exp) begin
          failures++;
          $display("FAIL div%0d_edge%0d clk_rx got=%b exp=%b", d, k, o_clk_rx, exp);
        end
      end
      i_en = 1'b0;
      step();
      checks++; if (o_clk_rx !== 1'b0) begin failures++; $display("FAIL div_disable clk_rx got=%b exp=0", o_clk_rx); end
    end
    // Lowering the divisor below the running count wraps on the next edge.
    i_div = DW'(20); i_en = 1'b1;
    for (int k = 0; k < 10; k++) step();
    checks++; if (o_clk_rx !== 1'b0) begin failures++; $display("FAIL div_lower_pre clk_rx got=%b exp=0", o_clk_rx); end
    i_div = DW'(2);
    step();
    checks++; if (o_clk_rx !== 1'b1) begin failures++; $display("FAIL div_lower_wrap clk_rx got=%b exp=1", o_clk_rx); end
    i_div = DW'(3);
  endtask

  task automatic test_single_drain();
    int p, f; logic [7:0] h, got; bit gv;
    send_char(8'hA5, 2, 1'b0, 1'b0, p, f, h);
    checks++; if (p != 1 || f != 0) begin failures++; $display("FAIL single_re pulses=%0d first=%0d exp 1,0", p, f); end
    checks++; if (o_valid !== 1'b1 || o_data !== 8'hA5) begin failures++; $display("FAIL single_head valid=%b data=%h exp 1,a5", o_valid, o_data); end
    checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", o_count); end
    pop_one(got, gv);
    checks++; if (!gv || got !== 8'hA5) begin failures++; $display("FAIL single_pop got=%h v=%b exp=a5", got, gv); end
    checks++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin failures++; $display("FAIL single_empty count=%0d valid=%b exp 0,0", o_count, o_valid); end
  endtask

  task automatic test_fill_overrun();
    int p, f; logic [7:0] h, got, exp; bit gv;
    for (int i = 1; i <= 5; i++) begin
      send_char(8'(i), 0, 1'b0, 1'b0, p, f, h);
      checks++; if (p != 1) begin failures++; $display("FAIL fill_re%0d pulses=%0d exp=1", i, p); end
    end
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", o_count); end
    checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL fill_overrun got=%b exp=1", o_overrun); end
    // Drop coinciding with a clear: the flag must stay set.
    send_char(8'h06, 0, 1'b0, 1'b1, p, f, h);
    checks++; if (p != 1 || o_overrun !== 1'b1) begin failures++; $display("FAIL set_wins pulses=%0d ovr=%b exp 1,1", p, o_overrun); end
    for (int i = 1; i <= 4; i++) begin
      exp = q[0];
      pop_one(got, gv);
      checks++; if (!gv || got !== exp || got !== 8'(i)) begin failures++; $display("FAIL fill_pop%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL fill_drained valid=%b exp=0", o_valid); end
    clr_ovr();
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL fill_clr overrun=%b exp=0", o_overrun); end
  endtask

  task automatic test_full_pop();
    int p, f; logic [7:0] h, got, exp; bit gv;
    for (int i = 0; i < 4; i++) send_char(8'h11 + 8'(i), 0, 1'b0, 1'b0, p, f, h);
    send_char(8'h66, 0, 1'b1, 1'b0, p, f, h);
    checks++; if (h !== 8'h11) begin failures++; $display("FAIL fullpop_head got=%h exp=11", h); end
    checks++; if (o_count !== 3'd4 || o_overrun !== 1'b0) begin failures++; $display("FAIL fullpop_state count=%0d ovr=%b exp 4,0", o_count, o_overrun); end
    for (int i = 0; i < 4; i++) begin
      exp = q[0];
      pop_one(got, gv);
      checks++; if (!gv || got !== exp) begin failures++; $display("FAIL fullpop_pop%0d got=%h exp=%h", i, got, exp); end
    end
    checks++; if (got !== 8'h66) begin failures++; $display("FAIL fullpop_last got=%h exp=66", got); end
  endtask

  task automatic test_sticky();
    int p, f; logic [7:0] h, got; bit gv;
    send_char(8'h3C, 10, 1'b0, 1'b0, p, f, h);
    checks++; if (p != 1) begin failures++; $display("FAIL sticky_re pulses=%0d exp=1", p); end
    checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL sticky_count got=%0d exp=1", o_count); end
    pop_one(got, gv);
    checks++; if (got !== 8'h3C) begin failures++; $display("FAIL sticky_data got=%h exp=3c", got); end
  endtask

  task automatic test_reset_mid();
    int p, f; logic [7:0] h, got; bit gv;
    for (int i = 0; i < 5; i++) send_char(8'hB0 + 8'(i), 0, 1'b0, 1'b0, p, f, h);
    pop_one(got, gv);
    checks++; if (o_count !== 3'd3 || o_overrun !== 1'b1) begin failures++; $display("FAIL midrst_pre count=%0d ovr=%b exp 3,1", o_count, o_overrun); end
    i_nrst = 1'b0;
    step();
    i_nrst = 1'b1;
    q.delete(); m_ovr = 1'b0;
    checks++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin failures++; $display("FAIL midrst_fifo count=%0d valid=%b exp 0,0", o_count, o_valid); end
    checks++; if (o_overrun !== 1'b0 || o_clk_rx !== 1'b0) begin failures++; $display("FAIL midrst_flags ovr=%b clk_rx=%b exp 0,0", o_overrun, o_clk_rx); end
  endtask

  task automatic test_random();
    int p, f, op; logic [7:0] h, got, exp, d; bit gv;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        d = 8'($urandom);
        send_char(d, $urandom_range(0, 3), 1'b0, 1'b0, p, f, h);
        checks++; if (p != 1) begin failures++; $display("FAIL rnd%0d_re pulses=%0d exp=1", it, p); end
      end else if (op == 2) begin
        exp = (q.size() != 0) ? q[0] : 8'h00;
        pop_one(got, gv);
        checks++; if (gv && got !== exp) begin failures++; $display("FAIL rnd%0d_pop got=%h exp=%h", it, got, exp); end
      end else begin
        clr_ovr();
      end
      checks++;
      if (o_count !== 3'(q.size()) || o_valid !== (q.size() != 0) || o_overrun !== m_ovr) begin
        failures++;
        $display("FAIL rnd%0d_state count=%0d valid=%b ovr=%b exp %0d,%b,%b", it, o_count, o_valid, o_overrun, q.size(), q.size() != 0, m_ovr);
      end
      if (q.size() != 0) begin
        checks++; if (o_data !== q[0]) begin failures++; $display("FAIL rnd%0d_head got=%h exp=%h", it, o_data, q[0]); end
      end
    end
  endtask

  initial begin
    i_nrst = 1'b0; i_en = 1'b1; i_div = DW'(3); i_rx_rdy = 1'b0;
    i_rx_data = '0; i_ready = 1'b0; i_clr_ovr = 1'b0; m_ovr = 1'b0;
    step(); step();
    test_reset();
    i_nrst = 1'b1; i_en = 1'b0;
    step();
    test_divisor();
    i_en = 1'b1;
    test_single_drain();
    test_fill_overrun();
    test_full_pop();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
